// File: rtl/aes_pkg.sv
// Shared AES-128 key-schedule types, constants and GF(2^8) helpers.
// Latency: n/a (types and pure combinational functions only).
// Backpressure: n/a.
package aes_pkg;

  localparam int          NR        = 10;
  localparam int          KEY_W     = 128;
  localparam logic [31:0] RCON_INIT = 32'h0100_0000;

  // Keys use [0:127] numbering: bit 0 is the MSB of byte 0 (column-wise order).
  typedef logic [0:KEY_W-1] key_t;
  typedef key_t             rk_arr_t [0:NR];

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    EXPAND = 2'd1,
    DONE   = 2'd2
  } ks_state_t;

  // Multiply by x in GF(2^8), reduction polynomial 0x11B.
  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] aa;
    p  = 8'h00;
    aa = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ aa;
      aa = xtime(aa);
    end
    return p;
  endfunction

  // S-box computed as inverse (x^254, so 0 maps to 0) followed by the affine map,
  // which avoids a 256-entry table per instance.
  function automatic logic [7:0] sbox(input logic [7:0] x);
    logic [7:0] r;
    logic [7:0] s;
    r = x;
    for (int i = 0; i < 6; i++) begin
      r = gf_mul(gf_mul(r, r), x);  // exponent 1,3,7,...,127
    end
    r = gf_mul(r, r);               // exponent 254
    s = r ^ {r[6:0], r[7]} ^ {r[5:0], r[7:6]} ^ {r[4:0], r[7:5]} ^ {r[3:0], r[7:4]} ^ 8'h63;
    return s;
  endfunction

endpackage

// File: rtl/key_gen.sv
// One AES-128 key-expansion step: next round key from the previous one.
// Latency: purely combinational, 0 cycles.
// Backpressure: none; output follows inputs.
// Ports: temp_key (previous round key), rcon (round constant word),
//        mx_key (XOR mask on result, tie to 0 for plain expansion), ko (next round key).
module key_gen
  import aes_pkg::*;
(
  input  logic [0:KEY_W-1] temp_key,
  input  logic [0:31]      rcon,
  input  logic [0:KEY_W-1] mx_key,
  output logic [0:KEY_W-1] ko
);

  logic [0:31] w0, w1, w2, w3;
  logic [0:31] t;
  logic [0:31] n0, n1, n2, n3;

  assign w0 = temp_key[0:31];
  assign w1 = temp_key[32:63];
  assign w2 = temp_key[64:95];
  assign w3 = temp_key[96:127];

  // SubWord(RotWord(w3)) xor rcon
  assign t = {sbox(w3[8:15]), sbox(w3[16:23]), sbox(w3[24:31]), sbox(w3[0:7])} ^ rcon;

  assign n0 = w0 ^ t;
  assign n1 = w1 ^ n0;
  assign n2 = w2 ^ n1;
  assign n3 = w3 ^ n2;

  assign ko = {n0, n1, n2, n3} ^ mx_key;

endmodule

// File: rtl/key_sched_ctrl.sv
// AES-128 key schedule controller: accepts a cipher key, expands and stores all 11 round keys.
// Latency: key accepted at edge T, rk[k] written at edge T+k, keys_valid high after T+10; rd_key 1 cycle.
// Backpressure: key_ready low during expansion (high when KEY_SCHED_RELOAD_EN is defined); no key buffering.
// Ports: clk, rst_n (async active-low), key_in/key_valid/key_ready (key handshake),
//        rd_idx/rd_key (registered round-key read, idx 11..15 reads zero), keys_valid, busy.
// Config macro: KEY_SCHED_RELOAD_EN -- accept a new key mid-expansion and restart immediately.
module key_sched_ctrl
  import aes_pkg::*;
#(
  parameter int NR = aes_pkg::NR
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [0:KEY_W-1] key_in,
  input  logic             key_valid,
  output logic             key_ready,
  input  logic [3:0]       rd_idx,
  output logic [0:KEY_W-1] rd_key,
  output logic             keys_valid,
  output logic             busy
);

  if (NR != 10) begin : g_nr_check
    $error("key_sched_ctrl: only NR=10 (AES-128) is supported");
  end

  ks_state_t        state, state_nxt;
  logic [3:0]       cnt;
  logic [0:31]      rcon;
  rk_arr_t          rk;
  logic [0:KEY_W-1] prev_key;
  logic [0:KEY_W-1] nxt_key;
  logic             accept;

  // key_ready is held low while reset is asserted so no key can slip in.
`ifdef KEY_SCHED_RELOAD_EN
  assign key_ready = rst_n;
`else
  assign key_ready = rst_n && (state != EXPAND);
`endif

  assign accept     = key_valid && key_ready;
  assign busy       = (state == EXPAND);
  assign keys_valid = (state == DONE);

  // Guarded so cnt = 0 (idle) or past NR never indexes outside the array.
  always_comb begin
    prev_key = '0;
    if (cnt >= 4'd1 && cnt <= 4'(NR)) prev_key = rk[cnt - 4'd1];
  end

  key_gen u_key_gen (
    .temp_key (prev_key),
    .rcon     (rcon),
    .mx_key   ({KEY_W{1'b0}}),
    .ko       (nxt_key)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (accept) state_nxt = EXPAND;
      EXPAND:  if (accept) state_nxt = EXPAND;
               else if (cnt == 4'(NR)) state_nxt = DONE;
      DONE:    if (accept) state_nxt = EXPAND;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt    <= 4'd0;
      rcon   <= 32'h0;
      rd_key <= '0;
      for (int i = 0; i <= NR; i++) rk[i] <= '0;
    end else begin
      rd_key <= (rd_idx <= 4'(NR)) ? rk[rd_idx] : '0;
      // A new key wins over the expansion step (only reachable in EXPAND with reload enabled).
      if (accept) begin
        rk[0] <= key_in;
        cnt   <= 4'd1;
        rcon  <= RCON_INIT;
      end else if (state == EXPAND) begin
        rk[cnt] <= nxt_key;
        rcon    <= {xtime(rcon[0:7]), 24'h0};
        cnt     <= cnt + 4'd1;
      end
    end
  end

endmodule

// File: tb/tb_key_sched_ctrl.sv
// Self-checking bench for key_sched_ctrl: directed keys with known AES-128 schedules,
// read results checked by a scoreboard monitor, control/timing checked inline.
module tb_key_sched_ctrl;

`ifdef KEY_SCHED_RELOAD_EN
  localparam bit RELOAD = 1'b1;
`else
  localparam bit RELOAD = 1'b0;
`endif

  localparam logic [127:0] KA   = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] KA1  = 128'ha0fafe1788542cb123a339392a6c7605;
  localparam logic [127:0] KA2  = 128'hf2c295f27a96b9435935807a7359f67f;
  localparam logic [127:0] KA10 = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
  localparam logic [127:0] KZ1  = 128'h62636363626363636263636362636363;
  localparam logic [127:0] KZ2  = 128'h9b9898c9f9fbfbaa9b9898c9f9fbfbaa;
  localparam logic [127:0] KZ10 = 128'hb4ef5bcb3e92e21123e951cf6f8f188e;

  logic         clk = 1'b0;
  logic         rst_n;
  logic [0:127] key_in;
  logic         key_valid;
  logic         key_ready;
  logic [3:0]   rd_idx;
  logic [0:127] rd_key;
  logic         keys_valid;
  logic         busy;

  int n_chk = 0;
  int n_err = 0;

  logic [127:0] exp_q[$];
  logic         rd_issue = 1'b0;
  logic         rd_pend_q = 1'b0;

  always #5 clk = ~clk;

  key_sched_ctrl #(.NR(10)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .key_in     (key_in),
    .key_valid  (key_valid),
    .key_ready  (key_ready),
    .rd_idx     (rd_idx),
    .rd_key     (rd_key),
    .keys_valid (keys_valid),
    .busy       (busy)
  );

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Scoreboard monitor: a read issued at one edge presents rd_key after the next edge.
  always @(posedge clk) rd_pend_q <= rd_issue;

  always @(negedge clk) begin
    if (rd_pend_q) begin
      if (exp_q.size() == 0) begin
        chk("rd_key_unexpected", rd_key, 128'h0);
      end else begin
        chk("rd_key", rd_key, exp_q.pop_front());
      end
    end
  end

  task automatic rd(input logic [3:0] idx, input logic [127:0] exp);
    @(negedge clk);
    rd_idx = idx;
    exp_q.push_back(exp);
    rd_issue = 1'b1;
    @(posedge clk);
    #1 rd_issue = 1'b0;
  endtask

  // Returns 1 ns after the accepting edge.
  task automatic send_key(input logic [127:0] k);
    int w;
    w = 0;
    @(negedge clk);
    while (!key_ready && w < 40) begin
      @(negedge clk);
      w++;
    end
    chk("key_ready_before_send", key_ready, 1);
    key_in    = k;
    key_valid = 1'b1;
    @(posedge clk);
    #1 key_valid = 1'b0;
  endtask

  task automatic wait_valid(output int cyc);
    cyc = 0;
    while (!keys_valid && cyc < 30) begin
      @(posedge clk);
      #1;
      cyc++;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int cyc;
    logic kv_seen;
    rst_n     = 1'b0;
    key_valid = 1'b0;
    key_in    = '0;
    rd_idx    = 4'd0;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    chk("rst_keys_valid", keys_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_rd_key", rd_key, 0);
    chk("rst_key_ready", key_ready, 0);
    @(negedge clk) rst_n = 1'b1;
    #1 chk("idle_key_ready", key_ready, 1);

    // FIPS-197 key: expansion timing and stored round keys
    send_key(KA);
    chk("a_busy", busy, 1);
    chk("a_keys_valid_low", keys_valid, 0);
    chk("a_key_ready_expand", key_ready, RELOAD);
    wait_valid(cyc);
    chk("a_latency", cyc, 10);
    chk("a_busy_done", busy, 0);
    chk("a_key_ready_done", key_ready, 1);
    rd(4'd0, KA);
    rd(4'd1, KA1);
    rd(4'd2, KA2);
    rd(4'd10, KA10);
    rd(4'd12, 128'h0);
    rd(4'd15, 128'h0);
    rd(4'd0, KA);

    // Back-to-back zero key from DONE
    send_key(128'h0);
    chk("z_keys_valid_drop", keys_valid, 0);
    chk("z_busy", busy, 1);
    wait_valid(cyc);
    chk("z_latency", cyc, 10);
    rd(4'd0, 128'h0);
    rd(4'd1, KZ1);
    rd(4'd2, KZ2);
    rd(4'd10, KZ10);

    // Reset mid-expansion (rd_idx=10 so rd_key is non-zero going in)
    send_key(KA);
    repeat (4) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_keys_valid", keys_valid, 0);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_rd_key", rd_key, 0);
    chk("mid_rst_key_ready", key_ready, 0);
    @(negedge clk) rst_n = 1'b1;
    #1 chk("post_rst_key_ready", key_ready, 1);
    kv_seen = 1'b0;
    repeat (15) begin
      @(posedge clk);
      #1;
      if (keys_valid || busy) kv_seen = 1'b1;
    end
    chk("post_rst_idle", kv_seen, 0);
    rd(4'd0, 128'h0);
    rd(4'd10, 128'h0);

    // key_valid held through expansion; zero key presented at the 4th edge after accept
    @(negedge clk);
    key_in    = KA;
    key_valid = 1'b1;
    @(posedge clk);
    #1 chk("hold_busy", busy, 1);
    repeat (3) @(posedge clk);
    #1 key_in = '0;
    @(posedge clk);
    #1 key_valid = 1'b0;
    wait_valid(cyc);
    chk("hold_latency", 4 + cyc, RELOAD ? 14 : 10);
    rd(4'd1, RELOAD ? KZ1 : KA1);
    rd(4'd10, RELOAD ? KZ10 : KA10);
    rd(4'd0, RELOAD ? 128'h0 : KA);

    repeat (3) @(negedge clk);
    chk("scoreboard_drain", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/key_sched_ctrl.md
KEY_SCHED_CTRL -- requirements
Module: key_sched_ctrl

Interface
REQ-001 SHALL have parameter NR, default 10, number of AES-128 rounds; only 10 is supported, any other value is an elaboration error.
REQ-002 SHALL have port clk  input  1  sole clock; all state updates on rising edge.
REQ-003 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port key_in  input  128  cipher key, bit 0 = MSB, column-wise byte order [0:127].
REQ-005 SHALL have port key_valid  input  1  key_in valid for handshake.
REQ-006 SHALL have port key_ready  output  1  block can accept key_in.
REQ-007 SHALL have port rd_idx  input  4  round-key index to read, 0..10.
REQ-008 SHALL have port rd_key  output  128  registered round key for rd_idx, [0:127] order.
REQ-009 SHALL have port keys_valid  output  1  all NR+1 round keys stored and consistent.
REQ-010 SHALL have port busy  output  1  expansion in progress.

Function
REQ-011 SHALL implement FSM states IDLE, EXPAND, DONE.
REQ-012 Handshake: key accepted on rising edge where key_valid and key_ready are both 1; key_ready = 1 in IDLE and DONE, 0 in EXPAND (see REQ-025).
REQ-013 On accept: rk[0] <= key_in, round counter <= 1, rcon <= 32'h01000000, state <= EXPAND, keys_valid <= 0.
REQ-014 Each EXPAND cycle: rk[cnt] <= expansion step of rk[cnt-1] with current rcon; rcon <= xtime(rcon[0:7]) in byte 0, other bytes 0; cnt <= cnt+1.
REQ-015 rcon sequence for rounds 1..10 SHALL be 01,02,04,08,10,20,40,80,1B,36 (byte 0); 80 -> 1B wrap uses GF(2^8) reduction 0x11B.
REQ-016 When rk[10] is written (cnt = 10), state <= DONE; keys_valid = 1 and busy = 0 from the following cycle.
REQ-017 Latency: key accepted at edge T; rk[k] written at edge T+k; keys_valid high after edge T+10; exactly 10 EXPAND cycles.
REQ-018 busy = 1 exactly while state = EXPAND.
REQ-019 rd_key <= rk[rd_idx] each edge (1-cycle read latency); rd_idx 11..15 yields all-zero rd_key.
REQ-020 Reads during EXPAND return current register contents; consumers SHALL qualify with keys_valid.
REQ-021 New key accepted in DONE: keys_valid drops after that edge, re-expansion per REQ-013; rk[1..10] retain old values until overwritten.
REQ-022 key_valid with key_ready = 0 SHALL be ignored without state change; no key buffering.

Reset
REQ-023 rst_n low SHALL immediately force: state IDLE, cnt 0, rcon 0, rk[0..10] 0, rd_key 0, keys_valid 0, busy 0, key_ready 1 (after release).
REQ-024 Reset asserted mid-EXPAND SHALL abandon expansion; no partial keys_valid afterwards.

Configuration
REQ-025 Macro KEY_SCHED_RELOAD_EN: defined -> key_ready = 1 also in EXPAND; a key accepted in EXPAND restarts per REQ-013 on that edge. Undefined -> key_ready = 0 in EXPAND, behaviour per REQ-012.

Structure
REQ-026 Package aes_pkg SHALL hold: NR, key width 128, round-key array type, rcon initial value, xtime function, FSM state enum.
REQ-027 SHALL instantiate exactly one key_gen as the combinational expansion step: temp_key = rk[cnt-1], rcon = rcon register, mx_key tied to 0, ko = next round key; r_key unused.
REQ-028 Round-key storage SHALL be flops (11 x 128), no RAM macro.

Verification
REQ-029 Key 2b7e151628aed2a6abf7158809cf4f3c -> rk[1] = a0fafe1788542cb123a339392a6c7605, rk[10] = d014f9a8c9ee2589e13f0cc8b6630ca6, keys_valid exactly 10 cycles after accept.
REQ-030 Key all-zero -> rk[1] = 62636363626363636263636362636363, rk[10] = b4ef5bcb3e92e21123e951cf6f8f188e.
REQ-031 rd_idx = 12 after DONE -> rd_key = 0 next cycle; rd_idx = 0 -> original key.
REQ-032 rst_n pulsed low at EXPAND cycle 5 -> all outputs 0 asynchronously, keys_valid stays 0 until a new full expansion.
REQ-033 key_valid held high during EXPAND: macro undefined -> ignored, vector REQ-029 result unchanged; macro defined with zero key at cycle 4 -> restart, REQ-030 result 10 cycles later.
REQ-034 Back-to-back keys from DONE -> keys_valid low for exactly 10 cycles between results; rcon check reaches 36 at round 10.
